clk_en_nco_bank: RTL

//  Multi-channel fractional clock-enable generator. It derives NUM_CH independent

---
 rtl/clk_en_nco_pkg.sv | 30 +++
 rtl/clk_en_nco_ch.sv | 57 +++++
 rtl/clk_en_nco_bank.sv | 112 +++++++++++
 3 files changed

// File: rtl/clk_en_nco_pkg.sv
// Shared types and constants for the fractional clock-enable NCO bank.
package clk_en_nco_pkg;

  // Bank-level control state: settling (outputs held off) or running.
  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  // Width of the channel-select field on the config port (up to 16 channels).
  localparam int CH_IDX_W        = 4;
  localparam int DEF_ACC_W       = 32;
  localparam int DEF_LOCK_CYCLES = 16;

  // Phase increment for a wanted strobe rate: f_out * 2^acc_w / f_clk, truncated.
  // Intended for elaboration-time use by tops and benches; returns 0 for f_clk == 0.
  function automatic logic [63:0] inc_from_hz(input logic [63:0]  f_out_hz,
                                              input logic [63:0]  f_clk_hz,
                                              input int unsigned  acc_w);
    logic [127:0] num;
    logic [127:0] den;
    num = {64'd0, f_out_hz} << acc_w;
    den = {64'd0, f_clk_hz};
    if (f_clk_hz == 64'd0) begin
      return 64'd0;
    end
    return 64'(num / den);
  endfunction

endpackage

// File: rtl/clk_en_nco_ch.sv
// One NCO channel: phase accumulator, increment register and the two strobe flops.
// The bank decides when the channel advances or is reloaded; this block only
// does the modulo arithmetic and derives the wrap and midpoint strobes.
module clk_en_nco_ch
  import clk_en_nco_pkg::*;
#(
  parameter int               ACC_W    = DEF_ACC_W,
  parameter logic [ACC_W-1:0] INC_INIT = '0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             advance,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_phase,
  output logic             ce,
  output logic             ce_half
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  // Modulo-2^ACC_W add with the carry kept as the top bit; the carry is the wrap strobe.
  function automatic logic [ACC_W:0] wrap_add(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Next accumulator value and carry for this channel.
  always_comb begin
    sum = wrap_add(acc, inc);
  end

  // Accumulator/increment update; a reload beats an advance and silences both strobes.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      inc     <= INC_INIT;
      ce      <= 1'b0;
      ce_half <= 1'b0;
    end else if (load) begin
      acc     <= load_phase;
      inc     <= load_inc;
      ce      <= 1'b0;
      ce_half <= 1'b0;
    end else if (advance) begin
      acc     <= sum[ACC_W-1:0];
      ce      <= sum[ACC_W];
      ce_half <= sum[ACC_W-1] & ~acc[ACC_W-1];
    end else begin
      ce      <= 1'b0;
      ce_half <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_en_nco_bank.sv
// Multi-channel fractional clock-enable generator. Each channel strobes ce at
// f_clk*inc/2^ACC_W and ce_half at its accumulator midpoint crossing. Any accepted
// reconfiguration drops locked and re-runs the settle window before strobes resume;
// channels that were not reconfigured hold their phase through that window.
module clk_en_nco_bank
  import clk_en_nco_pkg::*;
#(
  parameter int                      NUM_CH      = 4,
  parameter int                      ACC_W       = DEF_ACC_W,
  parameter int                      LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = '0
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic [ACC_W-1:0]    cfg_phase,
  input  logic [NUM_CH-1:0]   ch_en,
  output logic [NUM_CH-1:0]   ce,
  output logic [NUM_CH-1:0]   ce_half,
  output logic                locked
);

  localparam int                CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CH_IDX_W:0] CH_LIM   = NUM_CH[CH_IDX_W:0];

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             locked_d;
  logic             ready_d;
  logic             ch_ok;
  logic             accept;

  // Out-of-range channel indices complete the handshake but are otherwise ignored.
  always_comb begin
    ch_ok = ({1'b0, cfg_ch} < CH_LIM);
  end

  // Control state, settle counter and the registered status outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= SETTLE;
      cnt       <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      locked    <= locked_d;
      cfg_ready <= ready_d;
    end
  end

  // Next-state logic: count out the settle window, then run until a valid reconfig.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    locked_d = locked;
    ready_d  = cfg_ready;
    accept   = 1'b0;
    case (state)
      SETTLE: begin
        locked_d = 1'b0;
        ready_d  = 1'b0;
        if (cnt == CNT_LAST) begin
          state_d  = RUN;
          locked_d = 1'b1;
          ready_d  = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RUN: begin
        locked_d = 1'b1;
        ready_d  = 1'b1;
        if (cfg_valid && cfg_ready && ch_ok) begin
          accept   = 1'b1;
          state_d  = SETTLE;
          cnt_d    = '0;
          locked_d = 1'b0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  // One accumulator per channel; an accept edge freezes every channel for that edge.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_nco_ch #(
      .ACC_W    (ACC_W),
      .INC_INIT (INC_INIT[i*ACC_W +: ACC_W])
    ) u_ch (
      .refclk     (refclk),
      .rst        (rst),
      .advance    (locked & ch_en[i] & ~accept),
      .load       (accept & (cfg_ch == CH_IDX_W'(i))),
      .load_inc   (cfg_inc),
      .load_phase (cfg_phase),
      .ce         (ce[i]),
      .ce_half    (ce_half[i])
    );
  end

endmodule
